bar_fetch_arbiter: RTL and testbench
====================================

BAR_FETCH_ARBITER -- requirements
Module: bar_fetch_arbiter

Interface
REQ-001 Parameter NUM_BARS, default 20, number of spectrum bars held in bar-height memory.
REQ-002 Parameter HEIGHT_W, default 9, bits per bar height.
REQ-003 Clk  in  1  system clock, 50 MHz domain shared with vga_controller.
REQ-004 Reset  in  1  synchronous, active-high.
REQ-005 line_start  in  1  single-cycle pulse at start of horizontal blanking.
REQ-006 cpu_wr_valid  in  1  CPU write request.
REQ-007 cpu_wr_ready  out  1  CPU write accepted when valid and ready are both high.
REQ-008 cpu_wr_addr  in  5  bar index to write.
REQ-009 cpu_wr_data  in  HEIGHT_W  bar height to write.
REQ-010 mem_addr  out  5  single-port bar RAM address.
REQ-011 mem_we  out  1  RAM write enable.
REQ-012 mem_wdata  out  HEIGHT_W  RAM write data.
REQ-013 mem_rdata  in  HEIGHT_W  RAM read data, valid exactly 1 cycle after mem_addr is presented.
REQ-014 bar_idx  in  5  bar index requested by color mapper.
REQ-015 bar_height  out  HEIGHT_W  displayed height for bar_idx, combinational.
REQ-016 prefetch_busy  out  1  high while a line prefetch is in progress.
REQ-017 overrun_cnt  out  8  saturating count of dropped line_start pulses.
REQ-018 addr_err  out  1  sticky flag, CPU write to an index >= NUM_BARS.

Function
REQ-019 FSM states shall be IDLE, PREFETCH, WAIT, COMMIT.
REQ-020 IDLE: cpu_wr_ready = !line_start; on an accepted write, mem_addr=cpu_wr_addr, mem_wdata=cpu_wr_data, mem_we=1 in the same cycle.
REQ-021 IDLE with line_start high -> PREFETCH, fetch index k=0; line_start beats a simultaneous cpu_wr_valid (write is not accepted).
REQ-022 PREFETCH: mem_we=0, mem_addr=k, k increments each cycle; after issuing k=NUM_BARS-1 -> WAIT.
REQ-023 Read data returned in the cycle after address k is issued shall be written into shadow buffer entry k (in PREFETCH and WAIT).
REQ-024 WAIT lasts 1 cycle (captures the last bar) -> COMMIT.
REQ-025 COMMIT copies all shadow entries into the display buffer in one cycle -> IDLE; the display buffer is never partially updated.
REQ-026 Latency: line_start in cycle 0 -> prefetch_busy high cycles 1..NUM_BARS+2; new heights visible on bar_height from cycle NUM_BARS+3 (23 for default).
REQ-027 cpu_wr_ready=0 in PREFETCH, WAIT and COMMIT; a pending CPU request holds its signals and completes on the first IDLE cycle.
REQ-028 line_start outside IDLE shall be ignored and overrun_cnt increments, saturating at 255.
REQ-029 CPU write with cpu_wr_addr >= NUM_BARS: accepted (handshake completes), mem_we held 0, addr_err set until Reset.
REQ-030 bar_idx >= NUM_BARS shall return bar_height=0.
REQ-031 When mem_we=0 and idle, mem_addr=0 and mem_wdata=0.

Reset
REQ-032 Reset shall force IDLE, k=0, shadow and display buffers to all zeros, overrun_cnt=0, addr_err=0, prefetch_busy=0, mem_we=0.
REQ-033 Reset asserted mid-prefetch shall abort the prefetch with no COMMIT; the display buffer reads 0 on the next cycle.

Structure
REQ-034 Package bar_pkg shall hold NUM_BARS default, HEIGHT_W default, BAR_IDX_W=5 and the FSM state enum.
REQ-035 Shadow/display double buffer and bar_idx read mux shall be sub-module bar_line_buffer; FSM, counter and arbitration stay in bar_fetch_arbiter.

Verification
REQ-036 CPU writes 100 to bar 3 in IDLE -> mem_we=1, mem_addr=3, mem_wdata=100 same cycle; after line_start, bar_idx=3 reads 100 from cycle 23.
REQ-037 line_start and cpu_wr_valid in same cycle -> ready=0, prefetch runs 22 busy cycles, write completes in cycle 23.
REQ-038 line_start pulsed at cycles 0 and 5 -> overrun_cnt=1, single COMMIT at cycle 22.
REQ-039 300 extra line_start pulses during back-to-back prefetches -> overrun_cnt saturates at 255.
REQ-040 CPU write to bar 25 -> handshake completes, mem_we=0, addr_err=1; bar_idx=25 returns 0.
REQ-041 Reset at cycle 10 of a prefetch -> IDLE next cycle, all bar_height=0, prefetch_busy=0.

Source files
------------

// File: rtl/bar_pkg.sv
// Shared constants and FSM state type for the spectrum bar fetch path.
package bar_pkg;

  localparam int NUM_BARS_DEF = 20;
  localparam int HEIGHT_W_DEF = 9;
  localparam int BAR_IDX_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_WAIT,
    ST_COMMIT
  } bar_state_t;

endpackage : bar_pkg

// File: rtl/bar_line_buffer.sv
// Shadow/display double buffer for bar heights with a guarded read mux
// for the color mapper.
module bar_line_buffer
  import bar_pkg::*;
#(
  parameter int NUM_BARS = NUM_BARS_DEF,
  parameter int HEIGHT_W = HEIGHT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap_en,
  input  logic [BAR_IDX_W-1:0] cap_idx,
  input  logic [HEIGHT_W-1:0]  cap_data,
  input  logic                 commit,
  input  logic [BAR_IDX_W-1:0] rd_idx,
  output logic [HEIGHT_W-1:0]  rd_data
);

  logic [HEIGHT_W-1:0] shadow_q  [NUM_BARS];
  logic [HEIGHT_W-1:0] display_q [NUM_BARS];

  // NOTE: both buffers are cleared on reset, so they are built from flops
  // rather than a RAM macro; a RAM could not be zeroed in a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        shadow_q[i]  <= '0;
        display_q[i] <= '0;
      end
    end else begin
      if (cap_en && (32'(cap_idx) < NUM_BARS)) begin
        shadow_q[cap_idx] <= cap_data;
      end
      // Whole-line copy keeps the displayed frame consistent.
      if (commit) begin
        for (int i = 0; i < NUM_BARS; i++) begin
          display_q[i] <= shadow_q[i];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < NUM_BARS) begin
      rd_data = display_q[rd_idx];
    end
  end

endmodule : bar_line_buffer

// File: rtl/bar_fetch_arbiter.sv
// Arbitrates the single-port bar RAM between CPU writes and a per-line
// prefetch that refreshes the displayed bar heights during blanking.
module bar_fetch_arbiter
  import bar_pkg::*;
#(
  parameter int NUM_BARS = NUM_BARS_DEF,
  parameter int HEIGHT_W = HEIGHT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 line_start,
  input  logic                 cpu_wr_valid,
  output logic                 cpu_wr_ready,
  input  logic [BAR_IDX_W-1:0] cpu_wr_addr,
  input  logic [HEIGHT_W-1:0]  cpu_wr_data,
  output logic [BAR_IDX_W-1:0] mem_addr,
  output logic                 mem_we,
  output logic [HEIGHT_W-1:0]  mem_wdata,
  input  logic [HEIGHT_W-1:0]  mem_rdata,
  input  logic [BAR_IDX_W-1:0] bar_idx,
  output logic [HEIGHT_W-1:0]  bar_height,
  output logic                 prefetch_busy,
  output logic [7:0]           overrun_cnt,
  output logic                 addr_err
);

  localparam logic [BAR_IDX_W-1:0] LAST_IDX = BAR_IDX_W'(NUM_BARS - 1);

  bar_state_t           state_q, state_d;
  logic [BAR_IDX_W-1:0] k_q, k_d;
  logic                 rd_valid_q;
  logic [BAR_IDX_W-1:0] rd_idx_q;
  logic                 commit;
  logic                 addr_bad;

  // NOTE: every output and next-state value is defaulted first so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cpu_wr_ready = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    commit       = 1'b0;
    addr_bad     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cpu_wr_ready = !line_start;
        if (line_start) begin
          state_d = ST_PREFETCH;
          k_d     = '0;
        end else if (cpu_wr_valid) begin
          // Out-of-range writes still handshake but never reach the RAM.
          if (32'(cpu_wr_addr) < NUM_BARS) begin
            mem_we    = 1'b1;
            mem_addr  = cpu_wr_addr;
            mem_wdata = cpu_wr_data;
          end else begin
            addr_bad = 1'b1;
          end
        end
      end
      ST_PREFETCH: begin
        mem_addr = k_q;
        if (k_q == LAST_IDX) begin
          state_d = ST_WAIT;
          k_d     = '0;
        end else begin
          k_d = k_q + BAR_IDX_W'(1);
        end
      end
      ST_WAIT: begin
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      overrun_cnt <= '0;
      addr_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      // Read data arrives one cycle after the address, so remember which
      // index it belongs to.
      rd_valid_q <= (state_q == ST_PREFETCH);
      rd_idx_q   <= k_q;
      if (line_start && (state_q != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      if (addr_bad) begin
        addr_err <= 1'b1;
      end
    end
  end

  assign prefetch_busy = (state_q != ST_IDLE);

  bar_line_buffer #(
    .NUM_BARS (NUM_BARS),
    .HEIGHT_W (HEIGHT_W)
  ) u_line_buffer (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (rd_valid_q),
    .cap_idx  (rd_idx_q),
    .cap_data (mem_rdata),
    .commit   (commit),
    .rd_idx   (bar_idx),
    .rd_data  (bar_height)
  );

endmodule : bar_fetch_arbiter

// File: tb/tb_bar_fetch_arbiter.sv
// Self-checking bench for bar_fetch_arbiter: directed scenarios plus random
// traffic compared against a cycle-timeline model of the arbiter behaviour.
module tb_bar_fetch_arbiter;

  localparam int NB = 20;
  localparam int HW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          line_start = 1'b0;
  logic          cpu_wr_valid = 1'b0;
  logic          cpu_wr_ready;
  logic [4:0]    cpu_wr_addr = '0;
  logic [HW-1:0] cpu_wr_data = '0;
  logic [4:0]    mem_addr;
  logic          mem_we;
  logic [HW-1:0] mem_wdata;
  logic [HW-1:0] mem_rdata = '0;
  logic [4:0]    bar_idx = '0;
  logic [HW-1:0] bar_height;
  logic          prefetch_busy;
  logic [7:0]    overrun_cnt;
  logic          addr_err;

  bar_fetch_arbiter #(.NUM_BARS(NB), .HEIGHT_W(HW)) dut (
    .clk           (clk),
    .reset         (reset),
    .line_start    (line_start),
    .cpu_wr_valid  (cpu_wr_valid),
    .cpu_wr_ready  (cpu_wr_ready),
    .cpu_wr_addr   (cpu_wr_addr),
    .cpu_wr_data   (cpu_wr_data),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .bar_idx       (bar_idx),
    .bar_height    (bar_height),
    .prefetch_busy (prefetch_busy),
    .overrun_cnt   (overrun_cnt),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  // External single-port RAM with one-cycle read latency.
  logic [HW-1:0] ram [32];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: busy_left counts remaining busy cycles of a line refresh.
  int            busy_left;
  int            m_ovf;
  bit            m_aerr;
  bit            last_accept;
  logic [HW-1:0] m_ram  [32];
  logic [HW-1:0] m_snap [NB];
  logic [HW-1:0] m_disp [NB];

  task automatic model_reset();
    busy_left = 0;
    m_ovf     = 0;
    m_aerr    = 1'b0;
    for (int i = 0; i < NB; i++) m_disp[i] = '0;
  endtask

  task automatic step(input logic ls, input logic wv, input logic [4:0] wa,
                      input logic [HW-1:0] wd, input logic [4:0] bi, input logic rst);
    bit            busy, accept;
    logic          exp_we;
    logic [4:0]    exp_addr;
    logic [HW-1:0] exp_wd, exp_h;
    int            pos;
    @(negedge clk);
    line_start   = ls;
    cpu_wr_valid = wv;
    cpu_wr_addr  = wa;
    cpu_wr_data  = wd;
    bar_idx      = bi;
    reset        = rst;
    #1;
    busy     = (busy_left > 0);
    accept   = !busy && !ls && wv && !rst;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_wd   = '0;
    if (accept && (int'(wa) < NB)) begin
      exp_we   = 1'b1;
      exp_addr = wa;
      exp_wd   = wd;
    end
    if (busy) begin
      pos = (NB + 2) - busy_left;
      if (pos < NB) exp_addr = 5'(pos);
    end
    exp_h = (int'(bi) < NB) ? m_disp[bi] : '0;
    check("cpu_wr_ready", 32'(cpu_wr_ready), 32'(!busy && !ls));
    check("prefetch_busy", 32'(prefetch_busy), 32'(busy));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
    check("bar_height", 32'(bar_height), 32'(exp_h));
    check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovf));
    check("addr_err", 32'(addr_err), 32'(m_aerr));
    last_accept = accept;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (busy) begin
      if (ls && m_ovf < 255) m_ovf++;
      busy_left--;
      if (busy_left == 0) for (int i = 0; i < NB; i++) m_disp[i] = m_snap[i];
    end else if (ls) begin
      busy_left = NB + 2;
      for (int i = 0; i < NB; i++) m_snap[i] = m_ram[i];
    end else if (accept) begin
      if (int'(wa) < NB) m_ram[wa] = wd;
      else m_aerr = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] bi);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, '0, bi, 1'b0);
  endtask

  task automatic rand_cycles(input int n);
    logic ls, wv, rst;
    for (int i = 0; i < n; i++) begin
      ls  = ($urandom_range(0, 15) == 0);
      wv  = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        ls = 1'b0;
        wv = 1'b0;
      end
      step(ls, wv, 5'($urandom_range(0, 31)), HW'($urandom),
           5'($urandom_range(0, 31)), rst);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_ram[i] = HW'($urandom);
      ram[i]   = m_ram[i];
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state, then CPU write to bar 3 and a refresh picking it up.
    idle(1, 5'd3);
    step(1'b0, 1'b1, 5'd3, 9'd100, 5'd3, 1'b0);
    step(1'b1, 1'b0, 5'd0, '0, 5'd3, 1'b0);
    idle(23, 5'd3);

    // line_start collides with a CPU write; write held until first idle cycle.
    step(1'b1, 1'b1, 5'd5, 9'd77, 5'd5, 1'b0);
    for (int i = 0; i < 40 && !last_accept; i++) step(1'b0, 1'b1, 5'd5, 9'd77, 5'd5, 1'b0);
    check("held_write_done", 32'(last_accept), 32'd1);
    step(1'b1, 1'b0, 5'd0, '0, 5'd5, 1'b0);
    idle(23, 5'd5);

    // Second line_start five cycles into a refresh.
    step(1'b1, 1'b0, 5'd0, '0, 5'd7, 1'b0);
    idle(4, 5'd7);
    step(1'b1, 1'b0, 5'd0, '0, 5'd7, 1'b0);
    idle(20, 5'd7);

    // Continuous line_start across back-to-back refreshes saturates overruns.
    for (int i = 0; i < 400; i++) step(1'b1, 1'b0, 5'd0, '0, 5'(i % 32), 1'b0);
    idle(25, 5'd1);

    // Out-of-range write and read.
    step(1'b0, 1'b1, 5'd25, 9'd300, 5'd25, 1'b0);
    idle(2, 5'd25);

    rand_cycles(1500);

    // Reset in the tenth busy cycle of a refresh that follows a full one.
    idle(25, 5'd0);
    for (int i = 0; i < NB; i++) begin
      step(1'b0, 1'b1, 5'(i), HW'($urandom_range(1, 511)), 5'd0, 1'b0);
    end
    step(1'b1, 1'b0, 5'd0, '0, 5'd0, 1'b0);
    idle(23, 5'd0);
    step(1'b1, 1'b0, 5'd0, '0, 5'd2, 1'b0);
    idle(9, 5'd2);
    step(1'b0, 1'b0, 5'd0, '0, 5'd2, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, '0, 5'(i), 1'b0);

    rand_cycles(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bar_fetch_arbiter
